// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_pkg
//  Description : Shared FP32 constants, field struct and multiplier pipeline
//                payload types used by the FP32 multiplier and adder.
//  Revision    : 1.0  initial release
// ============================================================================
package fp32_pkg;

    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_MAX = 255;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    // Fields that travel unchanged from unpack through normalize.
    typedef struct packed {
        logic              sign;
        logic signed [9:0] esum;
        logic              exc;
        logic              zero;
    } stage_pl_t;

    typedef struct packed {
        stage_pl_t   pl;
        logic [23:0] ma;
        logic [23:0] mb;
    } s1_t;

    typedef struct packed {
        stage_pl_t   pl;
        logic [47:0] p;
    } s2_t;

    function automatic logic exp_is_special(input logic [7:0] e);
        return &e;
    endfunction

    function automatic logic [23:0] mant_with_hidden(input fp32_t x);
        return {|x.exp, x.frac};
    endfunction

endpackage
`default_nettype wire

// File: rtl/flmul_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : flmul_pipe_if
//  Description : Operand/result valid-ready bundle for the FP32 multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
interface flmul_pipe_if;

    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] res;
    logic        exception;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, res, exception, out_valid
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, res, exception, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/fp32_mul_norm.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_mul_norm
//  Description : Combinational normalize, range check and pack of a raw
//                24x24 mantissa product into an FP32 result (truncating).
//  Revision    : 1.0  initial release
// ============================================================================
module fp32_mul_norm
    import fp32_pkg::*;
(
    input  wire logic [47:0]       i_p,
    input  wire logic signed [9:0] i_esum,
    input  wire logic              i_sign,
    input  wire logic              i_exc,
    input  wire logic              i_zero,
    output logic [31:0]            o_res,
    output logic                   o_exception
);

    logic [22:0]       w_frac;
    logic signed [9:0] w_e;
    fp32_t             w_pack;
    logic              w_unused_lsbs;

    // Truncation rounding: bits below the kept fraction are simply dropped.
    assign w_unused_lsbs = ^i_p[22:0];

    always_comb begin
        if (i_p[47]) begin
            w_frac = i_p[46:24];
            w_e    = i_esum + 10'sd1;
        end else begin
            w_frac = i_p[45:23];
            w_e    = i_esum;
        end
    end

    always_comb begin
        w_pack.sign = i_sign;
        w_pack.exp  = w_e[7:0];
        w_pack.frac = w_frac;
    end

    always_comb begin
        o_res       = 32'h0000_0000;
        o_exception = 1'b0;
        if (i_exc) begin
            o_exception = 1'b1;
        end else if (w_e >= $signed(10'(FP32_EXP_MAX))) begin
            o_exception = 1'b1;
        end else if (i_zero || (w_e <= 10'sd0)) begin
            o_exception = 1'b0;
        end else begin
            o_res = w_pack;
        end
    end

endmodule
`default_nettype wire

// File: rtl/flmul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : flmul_pipe
//  Description : Three-stage FP32 multiplier (unpack, multiply, normalize)
//                with a single global advance and valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module flmul_pipe
    import fp32_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    flmul_pipe_if.slave bus
);

    logic        w_adv;
    fp32_t       w_a;
    fp32_t       w_b;
    logic signed [9:0] w_esum;
    logic [47:0] w_prod;
    logic [31:0] w_norm_res;
    logic        w_norm_exc;

    logic        r_v1_q, r_v2_q, r_v3_q;
    logic        w_v1_d, w_v2_d, w_v3_d;
    s1_t         r_s1_q, w_s1_d;
    s2_t         r_s2_q, w_s2_d;
    logic [31:0] r_res_q, w_res_d;
    logic        r_exc_q, w_exc_d;

    // Whole pipe moves in lockstep; only a stalled output slot blocks it.
    assign w_adv         = !r_v3_q || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_v3_q;
    assign bus.res       = r_res_q;
    assign bus.exception = r_exc_q;

    assign w_a    = bus.a;
    assign w_b    = bus.b;
    assign w_esum = $signed({2'b00, w_a.exp}) + $signed({2'b00, w_b.exp})
                  - $signed(10'(FP32_BIAS));
    assign w_prod = {24'h00_0000, r_s1_q.ma} * {24'h00_0000, r_s1_q.mb};

    fp32_mul_norm u_norm (
        .i_p         (r_s2_q.p),
        .i_esum      (r_s2_q.pl.esum),
        .i_sign      (r_s2_q.pl.sign),
        .i_exc       (r_s2_q.pl.exc),
        .i_zero      (r_s2_q.pl.zero),
        .o_res       (w_norm_res),
        .o_exception (w_norm_exc)
    );

    always_comb begin
        w_v1_d  = r_v1_q;
        w_v2_d  = r_v2_q;
        w_v3_d  = r_v3_q;
        w_s1_d  = r_s1_q;
        w_s2_d  = r_s2_q;
        w_res_d = r_res_q;
        w_exc_d = r_exc_q;
        if (w_adv) begin
            w_v1_d = bus.in_valid;
            w_s1_d = '0;
            if (bus.in_valid) begin
                w_s1_d.pl.sign = w_a.sign ^ w_b.sign;
                w_s1_d.pl.esum = w_esum;
                w_s1_d.pl.exc  = exp_is_special(w_a.exp) || exp_is_special(w_b.exp);
                w_s1_d.pl.zero = (w_a.exp == 8'h00) || (w_b.exp == 8'h00);
                w_s1_d.ma      = mant_with_hidden(w_a);
                w_s1_d.mb      = mant_with_hidden(w_b);
            end

            w_v2_d    = r_v1_q;
            w_s2_d.pl = r_s1_q.pl;
            w_s2_d.p  = w_prod;

            // Bubbles leave a clean zero in the output register.
            w_v3_d  = r_v2_q;
            w_res_d = r_v2_q ? w_norm_res : 32'h0000_0000;
            w_exc_d = r_v2_q && w_norm_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1_q  <= 1'b0;
            r_v2_q  <= 1'b0;
            r_v3_q  <= 1'b0;
            r_s1_q  <= '0;
            r_s2_q  <= '0;
            r_res_q <= 32'h0000_0000;
            r_exc_q <= 1'b0;
        end else begin
            r_v1_q  <= w_v1_d;
            r_v2_q  <= w_v2_d;
            r_v3_q  <= w_v3_d;
            r_s1_q  <= w_s1_d;
            r_s2_q  <= w_s2_d;
            r_res_q <= w_res_d;
            r_exc_q <= w_exc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flmul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flmul_pipe
//  Description : Self-checking bench for flmul_pipe against an arithmetic
//                FP32 truncating-multiply model and an in-order queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_flmul_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flmul_pipe_if bus ();

    flmul_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int n_out  = 0;
    logic [32:0] q[$];
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out   = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Returns {exception, res} from the number-format rules using plain integers.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int     ea;
        int     eb;
        int     e;
        longint ma;
        longint mb;
        longint prod;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {1'b1, 32'h0};
        if (ea == 0 || eb == 0)     return {1'b0, 32'h0};
        ma   = longint'({1'b1, a[22:0]});
        mb   = longint'({1'b1, b[22:0]});
        prod = ma * mb;
        e    = ea + eb - 127;
        if (prod >= (longint'(1) << 47)) begin
            prod = prod >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {1'b1, 32'h0};
        if (e <= 0)   return {1'b0, 32'h0};
        return {1'b0, a[31] ^ b[31], 8'(e), 23'(prod >> 23)};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        int sel;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0:       e = 8'hFF;
            1:       e = 8'h00;
            2:       e = 8'($urandom_range(190, 254));
            3:       e = 8'($urandom_range(1, 64));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    always @(negedge clk) begin
        logic [32:0] exp_v;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {bus.out_valid, bus.exception, bus.res}, prev_out);
            chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_v = q.pop_front();
                    chk("result", {bus.exception, bus.res}, exp_v);
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(ref_mul(bus.a, bus.b));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_valid, bus.exception, bus.res};
        end
    end

    task automatic cycle(input logic v, input logic [31:0] ta, input logic [31:0] tb,
                         input logic ordy, output logic acc);
        bus.in_valid  = v;
        bus.a         = ta;
        bus.b         = tb;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic measure(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                           input logic [32:0] req);
        logic acc;
        int   n;
        cycle(1'b1, ta, tb, 1'b1, acc);
        chk({nm, "_accept"}, acc, 1);
        n = 1;
        while (!bus.out_valid && n < 10) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
            n++;
        end
        chk({nm, "_latency"}, n, 3);
        chk({nm, "_value"}, {bus.exception, bus.res}, req);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          idx;
        int          base;
        logic [31:0] va[6];
        logic [31:0] vb[6];

        bus.in_valid  = 1'b0;
        bus.a         = 32'h0;
        bus.b         = 32'h0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_res", bus.res, 0);
        chk("reset_exception", bus.exception, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        chk("model_1p5x2", ref_mul(32'h3FC00000, 32'h40000000), {1'b0, 32'h40400000});
        chk("model_m2xhalf", ref_mul(32'hC0000000, 32'h3F000000), {1'b0, 32'hBF800000});
        chk("model_1x1", ref_mul(32'h3F800000, 32'h3F800000), {1'b0, 32'h3F800000});
        chk("model_1p5sq", ref_mul(32'h3FC00000, 32'h3FC00000), {1'b0, 32'h40100000});
        chk("model_inf", ref_mul(32'h7F800000, 32'h3F800000), {1'b1, 32'h0});
        chk("model_ovf", ref_mul(32'h7F000000, 32'h7F000000), {1'b1, 32'h0});
        chk("model_unf", ref_mul(32'h00800000, 32'h00800000), {1'b0, 32'h0});
        chk("model_denorm", ref_mul(32'h00400000, 32'h40000000), {1'b0, 32'h0});

        measure("lat_1p5x2", 32'h3FC00000, 32'h40000000, {1'b0, 32'h40400000});
        measure("lat_inf", 32'h7F800000, 32'h3F800000, {1'b1, 32'h0});
        measure("lat_ovf", 32'h7F000000, 32'h7F000000, {1'b1, 32'h0});
        measure("lat_unf", 32'h00800000, 32'h00800000, {1'b0, 32'h0});
        measure("lat_denorm", 32'h00400000, 32'h40000000, {1'b0, 32'h0});

        cycle(1'b1, 32'hC0000000, 32'h3F000000, 1'b1, acc);
        cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, acc);
        cycle(1'b1, 32'h3FC00000, 32'h3FC00000, 1'b1, acc);
        repeat (5) cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
        chk("directed_drained", q.size(), 0);

        // Six back-to-back operands with the output stalled in cycles 4..6.
        for (int i = 0; i < 6; i++) begin
            va[i] = rand_fp();
            vb[i] = 32'h3F800000 + 32'(i << 20);
        end
        idx  = 0;
        base = n_out;
        for (int k = 0; k < 16; k++) begin
            logic ordy;
            ordy = !(k >= 4 && k <= 6);
            if (idx < 6) begin
                bus.in_valid = 1'b1;
                bus.a        = va[idx];
                bus.b        = vb[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ordy;
            #1;
            if (!ordy) begin
                chk("bp_in_ready_low", bus.in_ready, 0);
                chk("bp_out_valid", bus.out_valid, 1);
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        chk("bp_all_accepted", idx, 6);
        chk("bp_all_delivered", n_out - base, 6);
        chk("bp_drained", q.size(), 0);

        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_fp(), rand_fp(),
                  1'($urandom_range(0, 3) != 0), acc);
        end
        repeat (6) cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
        chk("random_drained", q.size(), 0);

        // Reset with three items in flight.
        cycle(1'b1, 32'h40000000, 32'h40000000, 1'b1, acc);
        cycle(1'b1, 32'h3F800000, 32'h40400000, 1'b1, acc);
        cycle(1'b1, 32'hBF800000, 32'h40000000, 1'b1, acc);
        chk("pre_reset_full", bus.out_valid, 1);
        rst_n = 1'b0;
        cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_res", bus.res, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
            chk("post_rst_no_stale", bus.out_valid, 0);
        end
        measure("post_rst", 32'hC0000000, 32'h3F000000, {1'b0, 32'hBF800000});
        repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b1, acc);
        chk("final_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flmul_pipe.md
# flmul_pipe

Three-stage pipelined IEEE-754 single-precision multiplier with a valid/ready handshake on both sides. It sits directly upstream of the combinational FP32 adder/subtractor in the butterfly datapath: it forms the twiddle-factor products whose results the adder then sums. Its number-format rules match the adder so the two stages compose without fix-ups: hidden-bit handling, truncation rounding, and exception-to-zero.

## Interface
- Parameters: none; widths fixed at FP32.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- a  in  32  operand A, FP32
- b  in  32  operand B, FP32
- in_valid  in  1  a/b valid this cycle
- in_ready  out  1  pipeline accepts a/b this cycle
- res  out  32  product, FP32
- exception  out  1  qualifies res; 1 when an operand exponent is 255 or the product overflowed
- out_valid  out  1  res/exception valid
- out_ready  in  1  downstream accepts res this cycle

## Operation
- Global advance: adv = !v3 | out_ready, where v1..v3 are the stage valid bits.
  - in_ready = adv.
  - All stages shift together when adv = 1. All stages hold when adv = 0.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- S1 (unpack) registers:
  - sign = a[31]^b[31]
  - ma = {|ea, a[22:0]}, mb = {|eb, b[22:0]}
  - esum = ea + eb − 127, 10-bit signed
  - exc = (&ea) | (&eb)
  - zero = (ea==0) | (eb==0)
- S2 (multiply) registers: p = ma*mb, 48 bits. sign, esum, exc and zero pass through.
- S3 (normalize/pack):
  - If p[47]: frac = p[46:24], e = esum+1.
  - Else: frac = p[45:23], e = esum.
  - Rounding is truncation, i.e. round toward zero.
- Result priority, highest first:
  - exc → res = 0, exception = 1.
  - e ≥ 255 → res = 0, exception = 1.
  - zero or e ≤ 0 → res = 0, exception = 0 (flush).
  - Otherwise → res = {sign, e[7:0], frac}, exception = 0.
- Denormal operands: hidden bit is 0. A denormal operand always flushes to 0.
- NaN/Inf are not propagated. Any exponent of 255 yields 0 with exception = 1, matching the adder.

## Timing
- Latency: 3 cycles from input transfer to out_valid. Throughput: 1 result per cycle while out_ready = 1.
- Reset values: v1 = v2 = v3 = 0, out_valid = 0, res = 0, exception = 0.
  - in_ready = 1 during and after reset, because v3 = 0.
  - Data registers clear to 0.
- Stall (out_valid & !out_ready):
  - All stages freeze and in_ready = 0.
  - res and exception stay stable until the transfer completes.
- Bubbles: when in_valid = 0 on an advance, a bubble with v = 0 enters S1. Bubbles occupy slots. No compaction is required.
- Simultaneous output transfer and input accept in the same cycle is legal at full rate.
- Reset mid-operation: every in-flight item is discarded. out_valid = 0 on the cycle after rst_n is sampled low.
- in_ready depends combinationally on out_ready. This is the only combinational in-to-out path.

## Structure
- Shared package fp32_pkg holds:
  - FP32_BIAS = 127, FP32_EXP_MAX = 255
  - typedef of the {sign, exp, frac} struct
  - typedef of the S1→S2→S3 stage payload struct
- The adder uses the same package constants.
- One combinational sub-module, fp32_mul_norm, implements the S3 normalize/range-check/pack logic. It takes p, esum, sign, exc and zero, and returns res and exception. It is reusable by future fused stages.
- The 24×24 multiply is a plain `*`, so synthesis maps it to DSP.

## Test plan
- 0x3FC00000 × 0x40000000, i.e. 1.5×2.0 → res 0x40400000, exception 0, out_valid exactly 3 cycles after the transfer.
- 0xC0000000 × 0x3F000000, i.e. −2.0×0.5 → 0xBF800000. Also 0x3F800000 × 0x3F800000 → 0x3F800000.
- 0x7F800000 × 0x3F800000 → res 0, exception 1. Overflow case 0x7F000000 × 0x7F000000 → res 0, exception 1.
- Underflow case 0x00800000 × 0x00800000 → res 0, exception 0. Denormal case 0x00400000 × 0x40000000 → res 0, exception 0.
- Back-pressure: stream 6 back-to-back operands and hold out_ready low for cycles 4–6. Required response:
  - in_ready is low during the hold and res is stable.
  - All 6 results arrive in order with none lost or duplicated.
- Reset with 3 items in flight: out_valid = 0 on the next cycle. No stale result appears after rst_n returns high. The first new result appears 3 cycles after its input transfer.
